sha_256_padder: RTL and testbench
=================================

Name: sha_256_padder

Overview:
- Byte-stream front end for sha_256_accelerator. Accepts a message one byte per cycle.
- Applies SHA-256 padding: 0x80, zero fill, then the 64-bit big-endian bit length.
- Emits 512-bit blocks over a valid/ready handshake, with first/last flags so the downstream core can select IV or chaining.
- It is the producer side of the core's input_data/input_valid interface.

Parameters:
- LEN_W, 61: width of the internal byte counter. Bit length is {count, 3'b000} zero-extended to 64 bits. Legal range 8..61.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ena  input  1  clock enable; when low, all state and outputs hold and in_ready=0
- in_byte  input  8  message byte
- in_valid  input  1  in_byte/in_last/in_keep valid
- in_keep  input  1  1 = in_byte is part of the message; 0 = no byte, allowed only with in_last (empty tail)
- in_last  input  1  this beat ends the message
- in_ready  output  1  padder accepts a beat this cycle
- block_data  output  512  block; message byte 0 at [511:504], byte 63 at [7:0]
- block_valid  output  1  block_data/flags valid
- block_first  output  1  first block of the message
- block_last  output  1  final (padded) block of the message
- block_ready  input  1  downstream accepts the block

Behaviour:
- Reset (rst=0, async):
  - state=S_FILL, ptr=0, count=0, first_pending=1.
  - Outputs: block_data=0, block_valid=0, block_first=0, block_last=0, in_ready=0 during reset.
  - Mid-operation reset discards any partial block and any unaccepted block.
- ena=0: no state change, no handshake completes, outputs hold their values.
- in_ready = ena & (state==S_FILL).
- A beat is accepted when in_valid & in_ready.
- S_FILL:
  - Accepted beat with in_keep=1: write in_byte at byte ptr, ptr++, count++.
  - If that write fills byte 63: go to S_EMIT with last=0.
  - If the beat also has in_last: set pad_pending; after any S_EMIT, go to S_PAD80 instead of S_FILL.
  - Accepted beat with in_last=1 and in_keep=0: go directly to S_PAD80; the empty message is legal.
  - in_keep=0 without in_last is a protocol error: the beat is ignored and consumed.
- S_PAD80: write 0x80 at ptr, ptr++.
  - If ptr was 63: go to S_EMIT (last=0), then S_ZERO.
  - Otherwise go to S_ZERO.
- S_ZERO: write 0x00 at ptr, one byte per cycle.
  - When ptr reaches 56: go to S_LEN.
  - If ptr wraps past 63: go to S_EMIT (last=0), resume S_ZERO at ptr=0.
- S_LEN: write {count,3'b0} as 64-bit big-endian into bytes 56..63 in one cycle; go to S_EMIT with last=1.
- S_EMIT:
  - block_valid=1.
  - block_first = first_pending.
  - block_last = the last flag from the entering transition.
  - block_data is stable until block_valid & block_ready.
  - On handshake: clear the block register, ptr=0, first_pending=0, block_valid=0 next cycle.
  - Next state is S_FILL, S_PAD80 or S_ZERO, per the pending action.
  - After a last=1 handshake: count=0, first_pending=1, next state S_FILL (new message).
- Latency:
  - Block valid 1 cycle after the byte that fills it.
  - For padded tails: 1 (0x80) + zero bytes + 1 (length) cycles after in_last before block_valid.
- Only one block is buffered. in_ready is 0 throughout S_PAD80/S_ZERO/S_LEN/S_EMIT.
- Tail-length cases:
  - ptr <= 55 after the last byte: one padded block.
  - ptr in 56..63: an extra all-zero-plus-length block.
- Byte counter wraps modulo 2^LEN_W. Wrap is unchecked.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block:
  - bytes 0-3 = 61 62 63 80, bytes 4-55 = 0, bytes 56-63 = 00..00 18.
  - first=1, last=1.
- Empty message (single beat: in_last=1, in_keep=0) -> one block = 0x80 followed by 63 zero bytes (length 0), first=1, last=1.
- 55 bytes of 0xAA -> one block:
  - byte 55 = 0x80, length field 0x1B8.
  - first=1, last=1.
- 56 bytes of 0xAA -> two blocks:
  - Block 1: bytes 0-55 = AA, byte 56 = 80, bytes 57-63 = 0, first=1, last=0.
  - Block 2: bytes 0-55 = 0, length 0x1C0, first=0, last=1.
- 64 bytes 0x00..0x3F -> block 1 = raw data (first=1, last=0); block 2 = 80, zeros, length 0x200 (first=0, last=1).
- Holds and aborts:
  - block_ready low 10 cycles -> block_data/flags constant, in_ready=0.
  - ena low 5 cycles mid-fill -> nothing changes.
  - rst pulse after 20 bytes -> outputs 0; next message "abc" yields the "abc" block exactly.

Source files
------------

// File: rtl/sha_256_padder.sv
// SHA-256 message padder: collects a byte stream, appends 0x80, zero fill
// and the 64-bit big-endian bit length, and hands out 512-bit blocks with
// first/last flags for the downstream compression core.
//
// Handshakes: a beat moves on in_valid & in_ready, a block moves on
// block_valid & block_ready; once raised, block_valid and block_data/flags
// hold until the block is taken.

module sha_256_padder #(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block_data,
    output logic         block_valid,
    output logic         block_first,
    output logic         block_last,
    input  logic         block_ready
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD80,
        S_ZERO,
        S_LEN,
        S_EMIT
    } state_t;

    state_t           state;
    state_t           resume_state;   // where to go after a non-final block is taken
    logic [5:0]       ptr;            // next byte slot in the block
    logic [LEN_W-1:0] count;          // message length in bytes
    logic             first_pending;  // next emitted block opens a message

    // Byte k of the block lives at bits [511-8k -: 8]; 511-8k == {~k, 3'b111}.
    logic [8:0]  wr_msb;
    logic [63:0] bit_len;

    assign wr_msb   = {~ptr, 3'b111};
    assign bit_len  = 64'({count, 3'b000});
    assign in_ready = rst & ena & (state == S_FILL);

    // Padder FSM: byte collection, padding, length insertion and block hand-off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FILL;
            resume_state  <= S_FILL;
            ptr           <= 6'd0;
            count         <= '0;
            first_pending <= 1'b1;
            block_data    <= '0;
            block_valid   <= 1'b0;
            block_first   <= 1'b0;
            block_last    <= 1'b0;
        end else if (ena) begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        if (in_keep) begin
                            block_data[wr_msb -: 8] <= in_byte;
                            ptr          <= ptr + 6'd1;
                            count        <= count + LEN_W'(1);
                            resume_state <= in_last ? S_PAD80 : S_FILL;
                            if (ptr == 6'd63) begin
                                state       <= S_EMIT;
                                block_valid <= 1'b1;
                                block_first <= first_pending;
                                block_last  <= 1'b0;
                            end else if (in_last) begin
                                state <= S_PAD80;
                            end
                        end else if (in_last) begin
                            // Empty tail: the message ended on the previous byte.
                            state <= S_PAD80;
                        end
                        // keep=0 without last is dropped silently.
                    end
                end

                S_PAD80: begin
                    block_data[wr_msb -: 8] <= 8'h80;
                    ptr <= ptr + 6'd1;
                    if (ptr == 6'd63) begin
                        state        <= S_EMIT;
                        resume_state <= S_ZERO;
                        block_valid  <= 1'b1;
                        block_first  <= first_pending;
                        block_last   <= 1'b0;
                    end else if (ptr == 6'd55) begin
                        state <= S_LEN;
                    end else begin
                        state <= S_ZERO;
                    end
                end

                S_ZERO: begin
                    block_data[wr_msb -: 8] <= 8'h00;
                    ptr <= ptr + 6'd1;
                    if (ptr == 6'd63) begin
                        // No room for the length: ship this block, continue zeros.
                        state        <= S_EMIT;
                        resume_state <= S_ZERO;
                        block_valid  <= 1'b1;
                        block_first  <= first_pending;
                        block_last   <= 1'b0;
                    end else if (ptr == 6'd55) begin
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    block_data[63:0] <= bit_len;
                    state       <= S_EMIT;
                    block_valid <= 1'b1;
                    block_first <= first_pending;
                    block_last  <= 1'b1;
                end

                S_EMIT: begin
                    if (block_ready) begin
                        block_data  <= '0;
                        ptr         <= 6'd0;
                        block_valid <= 1'b0;
                        block_first <= 1'b0;
                        block_last  <= 1'b0;
                        if (block_last) begin
                            count         <= '0;
                            first_pending <= 1'b1;
                            state         <= S_FILL;
                        end else begin
                            first_pending <= 1'b0;
                            state         <= resume_state;
                        end
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_256_padder.sv
// Directed bench for sha_256_padder: known messages against hand-built
// padded blocks, plus stall, clock-enable and mid-message reset scenarios.

module tb_sha_256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_keep;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_first;
    logic         block_last;
    logic         block_ready;

    int checks   = 0;
    int failures = 0;

    logic [511:0] exp_blk;
    logic [511:0] got_d;
    logic         got_f;
    logic         got_l;
    int           lat;

    always #5 clk = ~clk;

    sha_256_padder #(.LEN_W(61)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_keep     (in_keep),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_first (block_first),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    function automatic logic [511:0] put(input logic [511:0] blk, input int idx, input logic [7:0] v);
        blk[511 - 8*idx -: 8] = v;
        return blk;
    endfunction

    // Drive one beat from a negedge and hold it until the edge that accepts it.
    task automatic send_beat(input logic [7:0] b, input logic keep, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_keep = keep; in_last = last;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL beat_timeout byte=%h waited=%0d limit=200", b, n);
        end
        @(posedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] start, input int n, input logic incr, input logic end_msg);
        for (int i = 0; i < n; i++)
            send_beat(incr ? start + 8'(i) : start, 1'b1, end_msg && (i == n - 1));
    endtask

    // Collect one block; lat = negedges without valid after the call starts.
    task automatic get_block(output logic [511:0] d, output logic f, output logic l, output int lt);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0; block_ready = 1'b1;
        while (block_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL block_timeout waited=%0d limit=300", n);
        end
        d = block_data; f = block_first; l = block_last; lt = n;
        @(negedge clk);
        block_ready = 1'b0;
        checks++;
        if (block_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_drop got=%b want=0", block_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        in_keep = 1'b0; in_last = 1'b0; block_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({block_data, block_valid, block_first, block_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got_valid=%b got_first=%b got_last=%b data=%h want all 0",
                     block_valid, block_first, block_last, block_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_abc();
        exp_blk = '0;
        exp_blk = put(exp_blk, 0, 8'h61);
        exp_blk = put(exp_blk, 1, 8'h62);
        exp_blk = put(exp_blk, 2, 8'h63);
        exp_blk = put(exp_blk, 3, 8'h80);
        exp_blk[63:0] = 64'h18;
        send_bytes(8'h61, 3, 1'b1, 1'b1);
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL abc_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b11) begin failures++; $display("FAIL abc_flags got=%b%b want=11", got_f, got_l); end
        // 0x80 edge + 52 zero edges + length edge after the accepting edge.
        checks++;
        if (lat != 54) begin failures++; $display("FAIL abc_latency got=%0d want=54", lat); end
    endtask

    task automatic test_empty();
        exp_blk = '0;
        exp_blk = put(exp_blk, 0, 8'h80);
        send_beat(8'h00, 1'b0, 1'b1);
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL empty_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b11) begin failures++; $display("FAIL empty_flags got=%b%b want=11", got_f, got_l); end
    endtask

    task automatic test_55();
        exp_blk = '0;
        for (int i = 0; i < 55; i++) exp_blk = put(exp_blk, i, 8'hAA);
        exp_blk = put(exp_blk, 55, 8'h80);
        exp_blk[63:0] = 64'h1B8;
        send_bytes(8'hAA, 55, 1'b0, 1'b1);
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL len55_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b11) begin failures++; $display("FAIL len55_flags got=%b%b want=11", got_f, got_l); end
    endtask

    task automatic test_56();
        send_bytes(8'hAA, 56, 1'b0, 1'b1);
        exp_blk = '0;
        for (int i = 0; i < 56; i++) exp_blk = put(exp_blk, i, 8'hAA);
        exp_blk = put(exp_blk, 56, 8'h80);
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL len56_b1_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b10) begin failures++; $display("FAIL len56_b1_flags got=%b%b want=10", got_f, got_l); end
        exp_blk = '0;
        exp_blk[63:0] = 64'h1C0;
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL len56_b2_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b01) begin failures++; $display("FAIL len56_b2_flags got=%b%b want=01", got_f, got_l); end
    endtask

    task automatic test_64();
        send_bytes(8'h00, 64, 1'b1, 1'b1);
        exp_blk = '0;
        for (int i = 0; i < 64; i++) exp_blk = put(exp_blk, i, 8'(i));
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL len64_b1_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b10) begin failures++; $display("FAIL len64_b1_flags got=%b%b want=10", got_f, got_l); end
        // Full block is visible right after the edge that accepts byte 63.
        checks++;
        if (lat != 0) begin failures++; $display("FAIL len64_latency got=%0d want=0", lat); end
        exp_blk = '0;
        exp_blk = put(exp_blk, 0, 8'h80);
        exp_blk[63:0] = 64'h200;
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if (got_d !== exp_blk) begin failures++; $display("FAIL len64_b2_data got=%h want=%h", got_d, exp_blk); end
        checks++;
        if ({got_f, got_l} !== 2'b01) begin failures++; $display("FAIL len64_b2_flags got=%b%b want=01", got_f, got_l); end
    endtask

    task automatic test_hold();
        int n;
        exp_blk = '0;
        exp_blk = put(exp_blk, 0, 8'h61);
        exp_blk = put(exp_blk, 1, 8'h62);
        exp_blk = put(exp_blk, 2, 8'h63);
        exp_blk = put(exp_blk, 3, 8'h80);
        exp_blk[63:0] = 64'h18;
        send_bytes(8'h61, 3, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (block_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({block_data, block_valid, block_first, block_last, in_ready} !== {exp_blk, 4'b1110}) begin
                failures++;
                $display("FAIL hold_cycle%0d got_v=%b got_f=%b got_l=%b got_rdy=%b data=%h want 1110 data=%h",
                         i, block_valid, block_first, block_last, in_ready, block_data, exp_blk);
            end
        end
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if ({got_d, got_f, got_l} !== {exp_blk, 2'b11}) begin
            failures++;
            $display("FAIL hold_release got=%h %b%b want=%h 11", got_d, got_f, got_l, exp_blk);
        end
    endtask

    task automatic test_ena();
        int n;
        exp_blk = '0;
        for (int i = 0; i < 11; i++) exp_blk = put(exp_blk, i, 8'h10 + 8'(i));
        exp_blk = put(exp_blk, 11, 8'h80);
        exp_blk[63:0] = 64'h58;
        send_bytes(8'h10, 10, 1'b1, 1'b0);
        // A tempting beat is presented while the enable is low; it must not land.
        @(negedge clk);
        ena = 1'b0; in_valid = 1'b1; in_byte = 8'hEE; in_keep = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({in_ready, block_valid} !== 2'b00) begin
                failures++;
                $display("FAIL ena_fill_cycle%0d got_rdy=%b got_v=%b want 00", i, in_ready, block_valid);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; ena = 1'b1;
        send_beat(8'h1A, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (block_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        // Downstream is ready but the enable is low: the block must stay put.
        ena = 1'b0; block_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({block_data, block_valid} !== {exp_blk, 1'b1}) begin
                failures++;
                $display("FAIL ena_emit_cycle%0d got_v=%b data=%h want v=1 data=%h", i, block_valid, block_data, exp_blk);
            end
        end
        block_ready = 1'b0; ena = 1'b1;
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if ({got_d, got_f, got_l} !== {exp_blk, 2'b11}) begin
            failures++;
            $display("FAIL ena_block got=%h %b%b want=%h 11", got_d, got_f, got_l, exp_blk);
        end
    endtask

    task automatic test_abort();
        send_bytes(8'h40, 20, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({block_data, block_valid, block_first, block_last, in_ready} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got_v=%b got_f=%b got_l=%b got_rdy=%b data=%h want all 0",
                     block_valid, block_first, block_last, in_ready, block_data);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_blk = '0;
        exp_blk = put(exp_blk, 0, 8'h61);
        exp_blk = put(exp_blk, 1, 8'h62);
        exp_blk = put(exp_blk, 2, 8'h63);
        exp_blk = put(exp_blk, 3, 8'h80);
        exp_blk[63:0] = 64'h18;
        send_bytes(8'h61, 3, 1'b1, 1'b1);
        get_block(got_d, got_f, got_l, lat);
        checks++;
        if ({got_d, got_f, got_l} !== {exp_blk, 2'b11}) begin
            failures++;
            $display("FAIL abort_abc got=%h %b%b want=%h 11", got_d, got_f, got_l, exp_blk);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_55();
        test_56();
        test_64();
        test_hold();
        test_ena();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
